// File: rtl/isram_loader_if.sv
// isram_loader_if: instruction word stream in, SRAM byte write port out
// Ports:
//   s_valid/s_word/s_ready : valid/ready stream of 4*N-bit instruction words
//   w_en/addr/data         : byte-wide SRAM write port (addr/data are 0 when w_en=0)
// master = producer/SRAM side, slave = loader side
interface isram_loader_if #(parameter int M = 10, parameter int N = 8);
  logic           s_valid;
  logic [4*N-1:0] s_word;
  logic           s_ready;
  logic           w_en;
  logic [M-1:0]   addr;
  logic [N-1:0]   data;
  modport master (output s_valid, s_word, input s_ready, w_en, addr, data);
  modport slave  (input s_valid, s_word, output s_ready, w_en, addr, data);
endinterface

// File: rtl/isram_loader.sv
// isram_loader: serializes stream words into byte writes to the instruction SRAM and holds the core until the image is loaded
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   start               : one-cycle load request, sampled in IDLE/DONE only
//   base_addr           : byte address of the first word (multiple of 4)
//   word_count          : number of words to load
//   bus (slave)         : word stream in, SRAM byte write port out
//   busy, done, err     : load in progress, last load finished, last start rejected
//   cpu_hold            : core held off while high
module isram_loader #(
  parameter int M = 10,
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [M-1:0] base_addr,
  input  logic [M-2:0] word_count,
  isram_loader_if.slave bus,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic         cpu_hold
);
  typedef enum logic [1:0] {IDLE, WAIT_WORD, WRITE, DONE} state_t;
  state_t         r_state, w_next;
  logic [M-1:0]   r_cur;
  logic [M-2:0]   r_rem;
  logic [1:0]     r_k;
  logic [4*N-1:0] r_sh;
  logic           r_err;
  logic           w_ctl;
  logic           w_hs;
  logic           w_bad;
  logic [M+1:0]   w_end;
  assign w_ctl = (r_state == IDLE) || (r_state == DONE);
  assign w_hs  = bus.s_valid && bus.s_ready;
  // end address in M+2 bits so an exact fit at 2**M is accepted and large counts never wrap
  assign w_end = {2'b00, base_addr} + {1'b0, word_count, 2'b00};
  assign w_bad = (|base_addr[1:0]) || (w_end > {2'b01, {M{1'b0}}});
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE, DONE: if (start) w_next = (w_bad || word_count == '0) ? DONE : WAIT_WORD;
      WAIT_WORD:  if (w_hs) w_next = WRITE;
      WRITE:      if (r_k == 2'd3) w_next = (r_rem == (M-1)'(1)) ? DONE : WAIT_WORD;
      default:    w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_cur <= '0;
      r_rem <= '0;
      r_k   <= '0;
      r_sh  <= '0;
      r_err <= 1'b0;
    end else begin
      if (w_ctl && start) begin
        r_cur <= base_addr;
        r_rem <= word_count;
        r_err <= w_bad;
      end
      if (w_hs) begin
        r_sh <= bus.s_word;
        r_k  <= '0;
      end
      // the shift register presents the MSB byte first, landing it at the lowest address
      if (r_state == WRITE) begin
        r_k  <= r_k + 2'd1;
        r_sh <= r_sh << N;
        if (r_k == 2'd3) begin
          r_cur <= r_cur + M'(4);
          r_rem <= r_rem - (M-1)'(1);
        end
      end
    end
  assign bus.s_ready = r_state == WAIT_WORD;
  assign bus.w_en    = r_state == WRITE;
  assign bus.addr    = bus.w_en ? r_cur + M'(r_k) : '0;
  assign bus.data    = bus.w_en ? r_sh[4*N-1 -: N] : '0;
  assign busy        = (r_state == WAIT_WORD) || (r_state == WRITE);
  assign done        = r_state == DONE;
  assign err         = r_err;
  assign cpu_hold    = !(done && !r_err);
endmodule

// File: tb/tb_isram_loader.sv
// tb_isram_loader: directed checks of the instruction SRAM loader
module tb_isram_loader;
  logic       clk;
  logic       rst;
  logic       start;
  logic [9:0] base_addr;
  logic [8:0] word_count;
  logic       busy, done, err, cpu_hold;
  int         vec = 0;
  int         bad = 0;
  int         wcnt = 0;
  int         viol = 0;
  int         w0;
  logic [7:0] mem [0:1023];
  logic [9:0] alog [$];
  isram_loader_if bus ();
  isram_loader dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .word_count(word_count),
    .bus(bus), .busy(busy), .done(done), .err(err), .cpu_hold(cpu_hold)
  );
  initial clk = 0;
  always #5 clk = ~clk;
  always @(posedge clk)
    if (bus.w_en) begin
      mem[bus.addr] <= bus.data;
      wcnt <= wcnt + 1;
      alog.push_back(bus.addr);
    end
  always @(negedge clk)
    if (bus.s_ready && bus.w_en) viol <= viol + 1;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask
  function automatic logic [31:0] rd(input int a);
    return {mem[a], mem[a+1], mem[a+2], mem[a+3]};
  endfunction
  task automatic do_start(input logic [9:0] b, input logic [8:0] c);
    start = 1;
    base_addr = b;
    word_count = c;
    @(negedge clk);
    start = 0;
  endtask
  task automatic send_word(input logic [31:0] w, input bit rnd);
    int n = 0;
    bus.s_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    bus.s_word = bus.s_valid ? w : $urandom;
    while (!(bus.s_valid && bus.s_ready) && n < 200) begin
      @(negedge clk);
      n++;
      if (rnd) begin
        bus.s_valid = 1'($urandom_range(0, 1));
        bus.s_word = bus.s_valid ? w : $urandom;
      end
    end
    chk("handshake", 32'(bus.s_valid && bus.s_ready), 1);
    @(negedge clk);
    bus.s_valid = 0;
    bus.s_word = $urandom;
  endtask
  task automatic wait_done(input string tag);
    int n = 0;
    while (!done && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(done), 1);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [7:0] b1 [4];
    b1 = '{8'h00, 8'h50, 8'h00, 8'h93};
    rst = 1;
    start = 0;
    base_addr = 0;
    word_count = 0;
    bus.s_valid = 0;
    bus.s_word = 0;
    @(negedge clk);
    chk("rst_s_ready", 32'(bus.s_ready), 0);
    chk("rst_w_en", 32'(bus.w_en), 0);
    chk("rst_addr", 32'(bus.addr), 0);
    chk("rst_data", 32'(bus.data), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_cpu_hold", 32'(cpu_hold), 1);
    rst = 0;
    @(negedge clk);
    // single word, byte-by-byte timing
    do_start(10'h000, 9'd1);
    chk("t1_ready", 32'(bus.s_ready), 1);
    chk("t1_busy", 32'(busy), 1);
    send_word(32'h00500093, 0);
    for (int k = 0; k < 4; k++) begin
      chk("t1_w_en", 32'(bus.w_en), 1);
      chk("t1_addr", 32'(bus.addr), 32'(k));
      chk("t1_data", 32'(bus.data), 32'(b1[k]));
      chk("t1_ready_in_write", 32'(bus.s_ready), 0);
      @(negedge clk);
    end
    chk("t1_done", 32'(done), 1);
    chk("t1_cpu_hold", 32'(cpu_hold), 0);
    chk("t1_busy_off", 32'(busy), 0);
    chk("t1_err", 32'(err), 0);
    chk("t1_w_en_off", 32'(bus.w_en), 0);
    chk("t1_addr_off", 32'(bus.addr), 0);
    chk("t1_word", rd(0), 32'h00500093);
    // three words with random valid backpressure
    w0 = wcnt;
    alog.delete();
    do_start(10'h010, 9'd3);
    chk("t2_cpu_hold", 32'(cpu_hold), 1);
    chk("t2_done_clr", 32'(done), 0);
    send_word(32'h11223344, 1);
    send_word(32'hAABBCCDD, 1);
    send_word(32'h0F1E2D3C, 1);
    wait_done("t2_done");
    chk("t2_count", 32'(wcnt - w0), 12);
    chk("t2_log", 32'(alog.size()), 12);
    for (int i = 0; i < 12; i++)
      if (i < alog.size()) chk("t2_order", 32'(alog[i]), 32'h10 + 32'(i));
    chk("t2_w0", rd(32'h10), 32'h11223344);
    chk("t2_w1", rd(32'h14), 32'hAABBCCDD);
    chk("t2_w2", rd(32'h18), 32'h0F1E2D3C);
    chk("t2_ready_write", 32'(viol), 0);
    chk("t2_err", 32'(err), 0);
    // exact fit at the top of memory
    w0 = wcnt;
    do_start(10'h3F8, 9'd2);
    send_word(32'hDEADBEEF, 0);
    send_word(32'h01234567, 0);
    wait_done("t3_done");
    chk("t3_err", 32'(err), 0);
    chk("t3_cpu_hold", 32'(cpu_hold), 0);
    chk("t3_count", 32'(wcnt - w0), 8);
    chk("t3_w0", rd(32'h3F8), 32'hDEADBEEF);
    chk("t3_w1", rd(32'h3FC), 32'h01234567);
    // one word past the top is rejected
    w0 = wcnt;
    do_start(10'h3F8, 9'd3);
    chk("t3b_done", 32'(done), 1);
    chk("t3b_err", 32'(err), 1);
    chk("t3b_cpu_hold", 32'(cpu_hold), 1);
    chk("t3b_busy", 32'(busy), 0);
    repeat (3) @(negedge clk);
    chk("t3b_no_write", 32'(wcnt - w0), 0);
    chk("t3b_err_hold", 32'(err), 1);
    do_start(10'h004, 9'd256);
    chk("t3c_overflow_err", 32'(err), 1);
    // misaligned and zero-count starts
    w0 = wcnt;
    do_start(10'h002, 9'd1);
    chk("t4_mis_err", 32'(err), 1);
    chk("t4_mis_done", 32'(done), 1);
    chk("t4_mis_hold", 32'(cpu_hold), 1);
    do_start(10'h000, 9'd0);
    chk("t4_zero_done", 32'(done), 1);
    chk("t4_zero_err", 32'(err), 0);
    chk("t4_zero_hold", 32'(cpu_hold), 0);
    chk("t4_zero_busy", 32'(busy), 0);
    repeat (2) @(negedge clk);
    chk("t4_no_write", 32'(wcnt - w0), 0);
    // asynchronous reset during the second byte
    do_start(10'h020, 9'd1);
    send_word(32'hCAFEF00D, 0);
    @(negedge clk);
    chk("t5_byte1_addr", 32'(bus.addr), 32'h21);
    chk("t5_byte1_data", 32'(bus.data), 32'hFE);
    #2 rst = 1;
    #1;
    chk("t5_w_en", 32'(bus.w_en), 0);
    chk("t5_busy", 32'(busy), 0);
    chk("t5_cpu_hold", 32'(cpu_hold), 1);
    chk("t5_addr", 32'(bus.addr), 0);
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    chk("t5_done_rst", 32'(done), 0);
    do_start(10'h020, 9'd1);
    send_word(32'hCAFEF00D, 0);
    wait_done("t5_redone");
    chk("t5_err", 32'(err), 0);
    chk("t5_word", rd(32'h20), 32'hCAFEF00D);
    // start while busy is ignored
    w0 = wcnt;
    do_start(10'h040, 9'd2);
    send_word(32'h13579BDF, 0);
    start = 1;
    base_addr = 10'h100;
    word_count = 9'd1;
    @(negedge clk);
    start = 0;
    chk("t6_addr", 32'(bus.addr), 32'h41);
    chk("t6_w_en", 32'(bus.w_en), 1);
    send_word(32'h2468ACE0, 0);
    wait_done("t6_done");
    chk("t6_count", 32'(wcnt - w0), 8);
    chk("t6_w0", rd(32'h40), 32'h13579BDF);
    chk("t6_w1", rd(32'h44), 32'h2468ACE0);
    chk("t6_err", 32'(err), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end
endmodule
